// File: rtl/uart_rx_core.sv
// UART receive core. It samples the RX line at 16x, checks each frame against
// the LCR fields and queues the data byte and its status flags in a show-ahead FIFO.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | start-bit qualification, resampled at tick 7
// DATA   | shifting in 5..8 data bits, LSB first, one per 16 ticks
// PARITY | sampling the parity bit
// STOP   | sampling the first stop bit, then pushing the frame
module uart_rx_core #(
  parameter int DEPTH      = 16,
  parameter int RTS_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    baud_tick,
  input  logic                    serial_data_in,
  input  logic [4:0]              lcr_cfg,
  input  logic                    rd_en,
  output logic [7:0]              data_o,
  output logic                    data_valid,
  output logic                    parity_err,
  output logic                    framing_err,
  output logic                    break_det,
  output logic                    overrun_err,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    n_RTS
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // The second stop bit is never checked, so the stop-length field has no effect here.
  logic unused_stop_cfg;
  assign unused_stop_cfg = lcr_cfg[2];

  logic sync1_q, sync2_q, prev_q;
  logic line;
  assign line = sync2_q;

  // Two-flop synchronizer. The edge-detect copy follows the baud tick, so IDLE sees
  // a falling edge even when the edge falls between ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_data_in;
      sync2_q <= sync1_q;
      if (baud_tick) prev_q <= sync2_q;
    end
  end

  state_t      state_q, state_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  len_q, len_d;
  logic        par_en_q, par_en_d;
  logic        even_q, even_d;
  logic        par_q, par_d;
  logic        pe_q, pe_d;
  logic        push;
  logic [10:0] push_word;

  // Frame state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      len_q    <= '0;
      par_en_q <= 1'b0;
      even_q   <= 1'b0;
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      par_en_q <= par_en_d;
      even_q   <= even_d;
      par_q    <= par_d;
      pe_q     <= pe_d;
    end
  end

  // Next-state logic. Everything advances only on baud ticks.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    even_d    = even_q;
    par_d     = par_q;
    pe_d      = pe_q;
    push      = 1'b0;
    push_word = {(shift_q == 8'h00) && !(par_en_q && par_q) && !line, !line, pe_q, shift_q};
    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (prev_q && !line) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == 4'd7) begin
            tick_d = '0;
            if (line) begin
              state_d = IDLE;
            end else begin
              // The frame format is captured here, so later LCR writes affect only the next frame.
              state_d  = DATA;
              bit_d    = '0;
              shift_d  = '0;
              len_d    = lcr_cfg[1:0];
              par_en_d = lcr_cfg[3];
              even_d   = lcr_cfg[4];
              par_d    = 1'b0;
              pe_d     = 1'b0;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_q == 4'd15) begin
            tick_d         = '0;
            shift_d[bit_q] = line;
            bit_d          = bit_q + 3'd1;
            if (bit_q == {1'b0, len_q} + 3'd4) state_d = par_en_q ? PARITY : STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        PARITY: begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            par_d   = line;
            pe_d    = ((^shift_q) ^ line) != ~even_q;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        STOP: begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, rts_q;
  logic          pop_ok, push_ok, full;
  logic [10:0]   head;

  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = rd_en && (cnt_q != '0);
  assign push_ok = push && (!full || pop_ok);

  // Occupancy after this cycle's push and pop.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage. It has no reset because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  // FIFO pointers, the sticky overrun flag and flow control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      rts_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      if (pop_ok) ovr_q <= 1'b0;
      else if (push && !push_ok) ovr_q <= 1'b1;
      rts_q <= (cnt_d >= CW'(DEPTH - RTS_MARGIN));
    end
  end

  assign head        = mem_q[rd_q];
  assign data_valid  = (cnt_q != '0);
  assign data_o      = data_valid ? head[7:0] : 8'h00;
  assign parity_err  = data_valid & head[8];
  assign framing_err = data_valid & head[9];
  assign break_det   = data_valid & head[10];
  assign overrun_err = ovr_q;
  assign fifo_count  = cnt_q;
  assign n_RTS       = rts_q;

endmodule
